// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   Small in-order writeback queue placed between the execute/memory stages and
//   the register-file write port. Results are formatted at enqueue time, so
//   each entry already holds its final 32-bit value. Loads get byte/halfword
//   select and sign/zero extension, and misaligned loads are flagged. The head
//   entry drives the register-file port directly.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake
//   in_wb_en, in_rd   destination write enable and register index
//   in_wb_sel         result source: 00 ALU, 01 load, 10 PC+4, 11 ALU
//   in_alu_result, in_pc_plus4, in_load_word   candidate results
//   in_funct3, in_addr_lo                      load type and address low bits
//   rf_grant          register-file write port is free this cycle
//   rf_rd, rf_data, rf_write_en                register-file write port
//   pending_mask      registers with a queued write outstanding
//   misalign_err      one-cycle pulse after a misaligned entry retires
//   retire_count      wrapping count of retired entries
// -----------------------------------------------------------------------------
module writeback_unit #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wb_en,
   input  logic [4:0]  in_rd,
   input  logic [1:0]  in_wb_sel,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_pc_plus4,
   input  logic [31:0] in_load_word,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_lo,
   input  logic        rf_grant,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data,
   output logic        rf_write_en,
   output logic [31:0] pending_mask,
   output logic        misalign_err,
   output logic [31:0] retire_count
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wr;
      logic        mis;
   } entry_t;

   entry_t             q [DEPTH];
   logic [DEPTH-1:0]   vld;
   logic [PW-1:0]      head, tail;

   entry_t             new_e;
   logic [7:0]         byte_v;
   logic [15:0]        half_v;
   logic               head_v, push, pop;
   logic [DEPTH-1:0]   vld_n;
   logic [31:0]        mask_n;

   // Enqueue-time formatting
   always_comb begin
      byte_v     = in_load_word[{in_addr_lo, 3'b000} +: 8];
      half_v     = in_load_word[{in_addr_lo[1], 4'b0000} +: 16];
      new_e.data = in_alu_result;
      new_e.rd   = in_rd;
      new_e.mis  = 1'b0;
      case (in_wb_sel)
         2'b01: begin
            case (in_funct3)
               3'b000: new_e.data = {{24{byte_v[7]}}, byte_v};
               3'b100: new_e.data = {24'd0, byte_v};
               3'b001: begin
                  new_e.data = {{16{half_v[15]}}, half_v};
                  new_e.mis  = in_addr_lo[0];
               end
               3'b101: begin
                  new_e.data = {16'd0, half_v};
                  new_e.mis  = in_addr_lo[0];
               end
               3'b010: begin
                  new_e.data = in_load_word;
                  new_e.mis  = (in_addr_lo != 2'b00);
               end
               default: begin
                  new_e.data = in_load_word;
                  new_e.mis  = 1'b1;
               end
            endcase
         end
         2'b10:   new_e.data = in_pc_plus4;
         default: new_e.data = in_alu_result;
      endcase
      new_e.wr = in_wb_en && (in_rd != 5'd0) && !new_e.mis;
   end

   // Circular buffer: the queue is full exactly when the tail slot is occupied,
   // which is the same condition as count == DEPTH.
   assign in_ready    = !vld[tail];
   assign head_v      = vld[head];
   assign push        = in_valid && in_ready;
   assign pop         = head_v && (!q[head].wr || rf_grant);

   assign rf_write_en = head_v && q[head].wr;
   assign rf_rd       = head_v ? q[head].rd   : 5'd0;
   assign rf_data     = head_v ? q[head].data : 32'd0;

   // Next-state mask is built from the post-edge queue contents so the
   // registered mask always matches what the queue holds.
   always_comb begin
      entry_t e;
      vld_n = vld;
      if (pop)  vld_n[head] = 1'b0;
      if (push) vld_n[tail] = 1'b1;
      mask_n = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         e = (push && (tail == PW'(i))) ? new_e : q[i];
         if (vld_n[i] && e.wr) mask_n = mask_n | (32'd1 << e.rd);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld          <= '0;
         head         <= '0;
         tail         <= '0;
         pending_mask <= 32'd0;
         misalign_err <= 1'b0;
         retire_count <= 32'd0;
      end else begin
         vld          <= vld_n;
         pending_mask <= mask_n;
         misalign_err <= pop && q[head].mis;
         if (push) tail <= tail + 1'b1;
         if (pop) begin
            head         <= head + 1'b1;
            retire_count <= retire_count + 32'd1;
         end
      end
   end

   // Payload storage needs no reset; slot validity is tracked in vld.
   always_ff @(posedge clk) begin
      if (push) q[tail] <= new_e;
   end

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//   Random and directed stimulus checked against a queue-based reference
//   model. Inputs are driven after the falling edge, and outputs are compared
//   on the following falling edge.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_wb_en, rf_grant;
   logic [4:0]  in_rd, rf_rd;
   logic [1:0]  in_wb_sel, in_addr_lo;
   logic [31:0] in_alu_result, in_pc_plus4, in_load_word;
   logic [2:0]  in_funct3;
   logic [31:0] rf_data, pending_mask, retire_count;
   logic        rf_write_en, misalign_err;

   writeback_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_wb_en(in_wb_en), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
      .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
      .in_load_word(in_load_word), .in_funct3(in_funct3),
      .in_addr_lo(in_addr_lo), .rf_grant(rf_grant), .rf_rd(rf_rd),
      .rf_data(rf_data), .rf_write_en(rf_write_en),
      .pending_mask(pending_mask), .misalign_err(misalign_err),
      .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          rd;
      bit          wr;
      bit          mis;
   } ent_t;

   ent_t        mq[$];
   bit          exp_mis;
   logic [31:0] exp_rc;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Spec-level formatting: shifts and masks on the raw word.
   function automatic ent_t fmt();
      ent_t        e;
      logic [31:0] b, h;
      int          a;
      a = int'(in_addr_lo);
      b = (in_load_word >> (8 * a)) & 32'hFF;
      h = (in_load_word >> (16 * (a / 2))) & 32'hFFFF;
      e.rd = int'(in_rd);
      e.mis = 0;
      e.data = in_alu_result;
      if (in_wb_sel == 2'd2) e.data = in_pc_plus4;
      else if (in_wb_sel == 2'd1) begin
         case (in_funct3)
            3'd0: e.data = (b > 127) ? (b | 32'hFFFFFF00) : b;
            3'd4: e.data = b;
            3'd1: begin e.data = (h > 32767) ? (h | 32'hFFFF0000) : h; e.mis = (a % 2) == 1; end
            3'd5: begin e.data = h; e.mis = (a % 2) == 1; end
            3'd2: begin e.data = in_load_word; e.mis = (a != 0); end
            default: begin e.data = in_load_word; e.mis = 1; end
         endcase
      end
      e.wr = in_wb_en && (e.rd != 0) && !e.mis;
      return e;
   endfunction

   function automatic logic [31:0] model_mask();
      logic [31:0] m = 32'd0;
      foreach (mq[i]) if (mq[i].wr) m[mq[i].rd] = 1'b1;
      return m;
   endfunction

   task automatic check_all(input string pfx);
      chk({pfx, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
      chk({pfx, ".rf_write_en"}, 32'(rf_write_en), 32'(mq.size() > 0 && mq[0].wr));
      chk({pfx, ".rf_rd"}, 32'(rf_rd), (mq.size() > 0) ? 32'(mq[0].rd) : 32'd0);
      chk({pfx, ".rf_data"}, rf_data, (mq.size() > 0) ? mq[0].data : 32'd0);
      chk({pfx, ".pending_mask"}, pending_mask, model_mask());
      chk({pfx, ".misalign_err"}, 32'(misalign_err), 32'(exp_mis));
      chk({pfx, ".retire_count"}, retire_count, exp_rc);
   endtask

   // One clock: the model consumes the inputs held across the rising edge.
   task automatic step(input string pfx);
      bit rdy;
      ent_t e;
      @(posedge clk);
      rdy = mq.size() < DEPTH;
      e = fmt();
      exp_mis = 0;
      if (mq.size() > 0 && (!mq[0].wr || rf_grant)) begin
         exp_mis = mq[0].mis;
         void'(mq.pop_front());
         exp_rc = exp_rc + 32'd1;
      end
      if (in_valid && rdy) mq.push_back(e);
      @(negedge clk);
      check_all(pfx);
   endtask

   task automatic drv(input bit v, input bit en, input int rd, input int sel,
                      input logic [31:0] val, input int f3, input int a, input bit g);
      in_valid = v;  in_wb_en = en; in_rd = 5'(rd); in_wb_sel = 2'(sel);
      in_alu_result = val; in_pc_plus4 = val + 32'd4; in_load_word = val;
      in_funct3 = 3'(f3); in_addr_lo = 2'(a); rf_grant = g;
   endtask

   initial begin
      reset = 1'b1;
      drv(0, 0, 0, 0, 32'd0, 0, 0, 0);
      exp_mis = 0;
      exp_rc = 32'd0;
      repeat (2) @(negedge clk);
      check_all("rst");
      reset = 1'b0;

      // ALU write to x5.
      drv(1, 1, 5, 0, 32'h12345678, 0, 0, 1);
      step("alu");
      drv(0, 0, 0, 0, 32'd0, 0, 0, 1);
      step("alu_ret");
      step("alu_idle");

      // Load formatting cases.
      drv(1, 1, 3, 1, 32'h80FF7F01, 0, 2, 1); step("lb");
      drv(1, 1, 4, 1, 32'h80FF7F01, 4, 3, 1); step("lbu");
      drv(1, 1, 6, 1, 32'h80FF7F01, 5, 2, 1); step("lhu");
      drv(1, 1, 7, 1, 32'h80FF7F01, 2, 1, 1); step("lw_mis");
      drv(1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0); step("rd0");
      drv(0, 0, 0, 0, 32'd0, 0, 0, 0);
      repeat (3) step("drain1");

      // Stalled grant with three pushes, then drain.
      drv(1, 1, 9, 0, 32'hA0000001, 0, 0, 0);  step("stall1");
      drv(1, 1, 10, 0, 32'hA0000002, 0, 0, 0); step("stall2");
      drv(1, 1, 11, 0, 32'hA0000003, 0, 0, 0); step("stall3");
      step("stall4");
      step("stall5");
      drv(1, 1, 11, 0, 32'hA0000003, 0, 0, 1); step("rel1");
      drv(0, 0, 0, 0, 32'd0, 0, 0, 1);
      repeat (3) step("rel");

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
             $urandom_range(0, 3), $urandom, $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 9) < 7);
         step("rnd");
      end

      // Reset with two entries queued.
      drv(1, 1, 12, 0, 32'h11111111, 0, 0, 0); step("pre_rst1");
      drv(1, 1, 13, 0, 32'h22222222, 0, 0, 0); step("pre_rst2");
      drv(0, 0, 0, 0, 32'd0, 0, 0, 1);
      reset = 1'b1;
      mq.delete();
      exp_mis = 0;
      exp_rc = 32'd0;
      #1 check_all("rst_async");
      @(negedge clk);
      check_all("rst_hold");
      reset = 1'b0;

      // First handshake right after reset release.
      drv(1, 1, 14, 2, 32'h00001000, 0, 0, 1); step("post_rst");
      drv(0, 0, 0, 0, 32'd0, 0, 0, 1);
      repeat (2) step("post_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the writeback queue depth in entries (legal values 2 or 4).
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  the upstream result is valid.
REQ-005 in_ready  out  1  the queue can accept an entry this cycle.
REQ-006 in_wb_en  in  1  the instruction writes a destination register.
REQ-007 in_rd  in  5  destination register index.
REQ-008 in_wb_sel  in  2  result source: 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved (treated as ALU).
REQ-009 in_alu_result, in_pc_plus4, in_load_word  in  32 each  candidate results; in_load_word is the raw aligned memory word.
REQ-010 in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 in_addr_lo  in  2  low two bits of the load address.
REQ-012 rf_grant  in  1  the register-file write port is free this cycle.
REQ-013 rf_rd  out  5; rf_data  out  32; rf_write_en  out  1  register-file write port.
REQ-014 pending_mask  out  32  bit i = 1 while a queued entry will write register i.
REQ-015 misalign_err  out  1  one-cycle pulse when a misaligned load retires.
REQ-016 retire_count  out  32  count of retired entries.

Function
REQ-017 A handshake SHALL occur when in_valid && in_ready; in_ready SHALL be 1 when count < DEPTH, including the cycle in which the queue pops.
REQ-018 Formatting SHALL happen at enqueue, and the queue SHALL store the final 32-bit data, rd, a write flag and a misalign flag.
REQ-019 Load formatting SHALL work as follows: LB/LBU select byte in_addr_lo; LH/LHU select halfword in_addr_lo[1]; LW uses the whole word; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-020 A load SHALL be misaligned when it is LH/LHU with in_addr_lo[0] = 1, LW with in_addr_lo != 0, or has an undefined funct3; the stored write flag SHALL be 0 for a misaligned load.
REQ-021 The stored write flag SHALL equal in_wb_en && (in_rd != 0) && !misaligned.
REQ-022 The head entry SHALL drive rf_rd and rf_data combinationally; rf_write_en SHALL equal head valid && head write flag.
REQ-023 A head with write flag = 1 SHALL retire (pop) on an edge where rf_grant = 1, and SHALL hold while rf_grant = 0.
REQ-024 A head with write flag = 0 SHALL retire on the next edge regardless of rf_grant, with rf_write_en held at 0.
REQ-025 Minimum latency SHALL be: accepted at edge N, rf_write_en high in cycle N+1, register written at edge N+2 given grant; throughput SHALL be one entry per cycle.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged; a push when full SHALL be impossible because in_ready = 0.
REQ-027 pending_mask SHALL be the OR of one-hot(rd) over all valid entries with write flag = 1; bit 0 SHALL always be 0; the mask SHALL be registered state that updates on the same edge as the push/pop.
REQ-028 misalign_err SHALL be a registered pulse, high for exactly the one cycle after a misaligned entry retires.
REQ-029 retire_count SHALL increment by 1 per retire (write or not) and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 Reset SHALL, asynchronously: empty the queue; force in_ready = 1, rf_write_en = 0, rf_rd = 0, rf_data = 0, pending_mask = 0, misalign_err = 0 and retire_count = 0; and discard any in-flight entries without writing them.
REQ-031 The first handshake after reset SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-032 ALU result 0x12345678 with rd = 5 and rf_grant = 1 -> one cycle later rf_write_en = 1, rf_rd = 5, rf_data = 0x12345678, pending_mask = 0x20; pending_mask clears after retire.
REQ-033 LB with word 0x80FF7F01 and addr_lo = 2 -> rf_data = 0xFFFFFFFF; LBU with addr_lo = 3 -> 0x00000080; LHU with addr_lo = 2 -> 0x000080FF.
REQ-034 LW with addr_lo = 1 and rd = 7 -> rf_write_en stays 0, misalign_err pulses for 1 cycle, retire_count increments by 1.
REQ-035 rd = 0 with in_wb_en = 1 -> no write, pending_mask bit 0 stays 0, entry retires without grant.
REQ-036 rf_grant = 0 for 5 cycles while pushing 3 entries (DEPTH = 2) -> in_ready drops after the 2nd entry; releasing the grant drains the queue in order with 1 write per cycle.
REQ-037 Reset asserted with 2 entries queued -> all outputs return to reset values immediately and no write occurs.
